// File: rtl/input_event_queue_pkg.sv
// Package input_pkg: types and constants shared by the input event queue and
// any other consumer of the input_sig conditioned level vector.
//   DEF_WIDTH / DEF_DEPTH : default line count and FIFO depth
//   IDX_W                 : width of a line index
//   EV_RISE / EV_FALL     : event kind encoding (press / release)
//   input_event_t         : one queued event {kind, idx}
package input_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_DEPTH = 4;
    localparam int IDX_W     = $clog2(DEF_WIDTH);

    localparam logic EV_RISE = 1'b1;
    localparam logic EV_FALL = 1'b0;

    typedef struct packed {
        logic             kind;
        logic [IDX_W-1:0] idx;
    } input_event_t;

endpackage

// File: rtl/input_event_queue_fifo.sv
// event_fifo: synchronous first-word fall-through FIFO of input_event_t.
// Ports:
//   clk, rst     clock, synchronous active-high reset (empties the FIFO)
//   push, din    write request and payload; ignored when full unless popping
//   pop          read request; ignored when empty
//   head         entry at the read pointer, valid whenever empty=0
//   count        entries stored (0..DEPTH)
//   full, empty  status flags
// DEPTH must be a power of two so the pointers wrap naturally.
module event_fifo
    import input_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  input_event_t           din,
    input  logic                   pop,
    output input_event_t           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);

    input_event_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
    assign pop_ok  = pop & ~empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign push_ok = push & (~full | pop_ok);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: nothing is visible until count says so.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/input_event_queue.sv
// input_event_queue: converts conditioned input levels into press/release
// events and queues them for a consumer with a valid/ready handshake.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   in_sig     conditioned line levels
//   ev_ready   consumer takes the head event this cycle
//   clr_ovf    clears the sticky overflow flag
//   ev_valid   an event is presented at the head
//   ev_idx     line index of the head event (0 when ev_valid=0)
//   ev_kind    1 = rise (press), 0 = fall (release); 0 when ev_valid=0
//   count      events currently queued
//   overflow   sticky: an edge was merged into an already-pending one
// Edges first land in per-line pending masks; one pending bit per cycle is
// moved into the FIFO, lowest rise index first, then lowest fall index.
// WIDTH must match input_pkg::DEF_WIDTH since the event index width is shared.
module input_event_queue
    import input_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       in_sig,
    input  logic                   ev_ready,
    input  logic                   clr_ovf,
    output logic                   ev_valid,
    output logic [IDX_W-1:0]       ev_idx,
    output logic                   ev_kind,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    logic [WIDTH-1:0] prev;
    logic             armed;
    logic [WIDTH-1:0] pend_rise;
    logic [WIDTH-1:0] pend_fall;

    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] sel_rise_mask;
    logic [WIDTH-1:0] sel_fall_mask;
    logic [WIDTH-1:0] clr_rise;
    logic [WIDTH-1:0] clr_fall;
    logic             sel_valid;
    input_event_t     sel_ev;
    input_event_t     head;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic             lost;

    // Nothing is detected until prev holds a real sample, so lines already
    // high when reset releases never look like a press.
    assign rise = armed ? (in_sig & ~prev) : '0;
    assign fall = armed ? (~in_sig & prev) : '0;

    // Scan from the highest index down so the lowest index wins; the rise
    // scan runs last so any pending rise beats every pending fall.
    always_comb begin
        sel_valid     = 1'b0;
        sel_ev        = '0;
        sel_rise_mask = '0;
        sel_fall_mask = '0;
        for (int i = WIDTH-1; i >= 0; i--) begin
            if (pend_fall[i]) begin
                sel_valid     = 1'b1;
                sel_ev.kind   = EV_FALL;
                sel_ev.idx    = IDX_W'(i);
                sel_rise_mask = '0;
                sel_fall_mask = '0;
                sel_fall_mask[i] = 1'b1;
            end
        end
        for (int i = WIDTH-1; i >= 0; i--) begin
            if (pend_rise[i]) begin
                sel_valid     = 1'b1;
                sel_ev.kind   = EV_RISE;
                sel_ev.idx    = IDX_W'(i);
                sel_rise_mask = '0;
                sel_fall_mask = '0;
                sel_rise_mask[i] = 1'b1;
            end
        end
    end

    assign pop  = ev_valid & ev_ready;
    assign push = sel_valid & (~full | pop);

    assign clr_rise = push ? sel_rise_mask : '0;
    assign clr_fall = push ? sel_fall_mask : '0;

    // A bit being drained this cycle can take a fresh edge without loss.
    assign lost = (|(rise & pend_rise & ~clr_rise)) |
                  (|(fall & pend_fall & ~clr_fall));

    always_ff @(posedge clk) begin
        if (rst) begin
            prev      <= '0;
            armed     <= 1'b0;
            pend_rise <= '0;
            pend_fall <= '0;
            overflow  <= 1'b0;
        end else begin
            prev      <= in_sig;
            armed     <= 1'b1;
            pend_rise <= (pend_rise & ~clr_rise) | rise;
            pend_fall <= (pend_fall & ~clr_fall) | fall;
            if (lost)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;
        end
    end

    event_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (sel_ev),
        .pop   (pop),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign ev_valid = ~empty;
    assign ev_idx   = ev_valid ? head.idx  : '0;
    assign ev_kind  = ev_valid ? head.kind : 1'b0;

endmodule

// File: tb/tb_input_event_queue.sv
// Directed bench for input_event_queue (WIDTH=4, DEPTH=4).
module tb_input_event_queue;

    logic       clk;
    logic       rst;
    logic [3:0] in_sig;
    logic       ev_ready;
    logic       clr_ovf;
    logic       ev_valid;
    logic [1:0] ev_idx;
    logic       ev_kind;
    logic [2:0] count;
    logic       overflow;

    int vec_cnt = 0;
    int err_cnt = 0;

    input_event_queue #(.WIDTH(4), .DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_sig   (in_sig),
        .ev_ready (ev_ready),
        .clr_ovf  (clr_ovf),
        .ev_valid (ev_valid),
        .ev_idx   (ev_idx),
        .ev_kind  (ev_kind),
        .count    (count),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit (got timeout, want finish)");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic v, input logic [1:0] idx, input logic kind);
        chk({tag, ".valid"}, 32'(ev_valid), 32'(v));
        chk({tag, ".idx"},   32'(ev_idx),   32'(idx));
        chk({tag, ".kind"},  32'(ev_kind),  32'(kind));
    endtask

    logic [1:0] exp_idx  [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd3, 2'd3};
    logic       exp_kind [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        rst = 1'b1; in_sig = 4'b0001; ev_ready = 1'b0; clr_ovf = 1'b0;

        // 1. line high through reset never produces a press
        repeat (3) tick();
        chk_head("rst", 1'b0, 2'd0, 1'b0);
        chk("rst.count", 32'(count), 32'd0);
        chk("rst.ovf", 32'(overflow), 32'd0);
        rst = 1'b0;
        repeat (5) tick();
        chk_head("arm_high", 1'b0, 2'd0, 1'b0);
        chk("arm_high.count", 32'(count), 32'd0);

        // the line then dropping is a real release
        in_sig = 4'b0000; ev_ready = 1'b1;
        tick();
        chk("rel0.lat1", 32'(ev_valid), 32'd0);
        tick();
        chk_head("rel0", 1'b1, 2'd0, 1'b0);
        tick();
        chk("rel0.gone", 32'(ev_valid), 32'd0);

        // 2. single press then release, latency and one-cycle width
        in_sig = 4'b0001;
        tick();
        chk("t2.lat1", 32'(ev_valid), 32'd0);
        tick();
        chk_head("t2.rise", 1'b1, 2'd0, 1'b1);
        tick();
        chk("t2.width", 32'(ev_valid), 32'd0);
        in_sig = 4'b0000;
        tick();
        tick();
        chk_head("t2.fall", 1'b1, 2'd0, 1'b0);
        tick();
        chk("t2.fall_gone", 32'(ev_valid), 32'd0);

        // 3. two rises in one cycle, drained lowest index first
        ev_ready = 1'b0; in_sig = 4'b1010;
        repeat (3) tick();
        chk("t3.count", 32'(count), 32'd2);
        ev_ready = 1'b1;
        chk_head("t3.ev0", 1'b1, 2'd1, 1'b1);
        tick();
        chk_head("t3.ev1", 1'b1, 2'd3, 1'b1);
        tick();
        chk("t3.empty", 32'(ev_valid), 32'd0);
        in_sig = 4'b0000;
        repeat (4) tick();
        chk("t3.flush", 32'(count), 32'd0);

        // 4. fill, block, overflow, clear, then 5. drain through a full FIFO
        ev_ready = 1'b0; in_sig = 4'b0111;
        repeat (4) tick();
        chk("t4.count3", 32'(count), 32'd3);
        in_sig = 4'b0110;
        repeat (2) tick();
        chk("t4.count4", 32'(count), 32'd4);
        in_sig = 4'b1110;
        tick();
        chk("t4.blocked", 32'(count), 32'd4);
        chk("t4.no_ovf", 32'(overflow), 32'd0);
        in_sig = 4'b0110;
        tick();
        in_sig = 4'b1110;
        tick();
        chk("t4.ovf", 32'(overflow), 32'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("t4.clr", 32'(overflow), 32'd0);
        ev_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk_head($sformatf("t4.drain%0d", i), 1'b1, exp_idx[i], exp_kind[i]);
            tick();
            if (i < 2)
                chk($sformatf("t5.full_pp%0d", i), 32'(count), 32'd4);
        end
        chk("t4.empty", 32'(ev_valid), 32'd0);
        chk("t4.count0", 32'(count), 32'd0);

        // 6. reset with queued and pending events, then clean re-arm
        ev_ready = 1'b0; in_sig = 4'b0001;
        repeat (4) tick();
        chk("t6.count3", 32'(count), 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_head("t6.rst", 1'b0, 2'd0, 1'b0);
        chk("t6.count", 32'(count), 32'd0);
        chk("t6.ovf", 32'(overflow), 32'd0);
        repeat (4) tick();
        chk("t6.rearm", 32'(count), 32'd0);
        chk("t6.rearm_v", 32'(ev_valid), 32'd0);
        in_sig = 4'b0000;
        repeat (2) tick();
        chk_head("t6.after", 1'b1, 2'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
